// File: rtl/fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register: PC, single-outstanding
// imem request/ack handshake, branch/jump redirect and stall hold buffer.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic [31:0] pc_r, pc_s;
    logic        req_r, req_s;
    logic [31:0] instr_r, instr_s;
    logic [31:0] pc4_r, pc4_s;
    logic        valid_r, valid_s;
    logic [31:0] buf_instr_r, buf_instr_s;
    logic [31:0] buf_pc4_r, buf_pc4_s;
    logic        redirect_s;
    logic [31:0] target_s;
    logic [31:0] pc_plus4_s;

    // Redirect decode: a stalled ID stage cannot redirect; jump beats branch.
    always_comb begin
        redirect_s = (jump | branch_taken) & ~stall;
        target_s   = jump ? jump_target : branch_target;
        pc_plus4_s = pc_r + 32'd4;
    end

    // Next-state, PC, IF/ID and hold-buffer logic.
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        instr_s     = instr_r;
        pc4_s       = pc4_r;
        valid_s     = valid_r;
        buf_instr_s = buf_instr_r;
        buf_pc4_s   = buf_pc4_r;
        if (redirect_s) begin
            // Every redirect squashes whatever sits in IF/ID (delay slot).
            pc_s    = target_s;
            instr_s = 32'h0000_0000;
            pc4_s   = 32'h0000_0000;
            valid_s = 1'b0;
        end else begin
            pc_s = pc_r;
        end
        case (state_r)
            ST_IDLE: begin
                state_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (redirect_s) begin
                    state_s = imem_ack ? ST_FETCH : ST_DRAIN;
                end else if (stall) begin
                    if (imem_ack) begin
                        buf_instr_s = imem_rdata;
                        buf_pc4_s   = pc_plus4_s;
                        pc_s        = pc_plus4_s;
                        state_s     = ST_HOLD;
                    end else begin
                        state_s = ST_FETCH;
                    end
                end else if (imem_ack) begin
                    instr_s = imem_rdata;
                    pc4_s   = pc_plus4_s;
                    valid_s = 1'b1;
                    pc_s    = pc_plus4_s;
                end else begin
                    instr_s = 32'h0000_0000;
                    pc4_s   = 32'h0000_0000;
                    valid_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                // The killed request's ack is swallowed; only then refetch.
                state_s = imem_ack ? ST_FETCH : ST_DRAIN;
            end
            ST_HOLD: begin
                if (redirect_s) begin
                    buf_instr_s = 32'h0000_0000;
                    buf_pc4_s   = 32'h0000_0000;
                    state_s     = ST_FETCH;
                end else if (stall) begin
                    state_s = ST_HOLD;
                end else begin
                    instr_s = buf_instr_r;
                    pc4_s   = buf_pc4_r;
                    valid_s = 1'b1;
                    state_s = ST_FETCH;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        req_s = (state_s == ST_FETCH);
    end

    // State, PC, request and IF/ID registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            pc_r        <= RESET_PC;
            req_r       <= 1'b0;
            instr_r     <= 32'h0000_0000;
            pc4_r       <= 32'h0000_0000;
            valid_r     <= 1'b0;
            buf_instr_r <= 32'h0000_0000;
            buf_pc4_r   <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            req_r       <= req_s;
            instr_r     <= instr_s;
            pc4_r       <= pc4_s;
            valid_r     <= valid_s;
            buf_instr_r <= buf_instr_s;
            buf_pc4_r   <= buf_pc4_s;
        end
    end

    assign imem_req       = req_r;
    assign imem_addr      = pc_r;
    assign if_id_instr    = instr_r;
    assign if_id_pc_plus4 = pc4_r;
    assign if_id_valid    = valid_r;

endmodule
